scramble_sequencer: RTL and testbench

- Downstream stage of the shuffle-request logic. Consumes the scramble-request level (random_please) and drives a fixed-length sequence of pseudo-random tile moves into the puzzle board over a valid/ready handshake.
- Generates the mix_state flag that the request logic uses to suppress further requests while a scramble is running.
- Pulses scramble_done when the last move is accepted, which hands control back to solve mode.

---
 rtl/scramble_sequencer.sv | 107 ++++++++++
 tb/tb_scramble_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scramble_sequencer.sv
// Issues a fixed-length burst of pseudo-random tile moves over a valid/ready
// handshake whenever a fresh scramble request arrives, then pulses scramble_done.
module scramble_sequencer #(
   parameter int          NUM_MOVES = 31,
   parameter int          MOVE_GAP  = 4,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       random_please,
   input  logic       move_ready,
   output logic       move_valid,
   output logic [1:0] move_dir,
   output logic       mix_state,
   output logic       scramble_done,
   output logic [7:0] moves_left
);

   localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [15:0] MASK = 16'hB400;
   localparam int GW = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
   localparam logic [GW-1:0] GAP_LOAD = (MOVE_GAP > 0) ? GW'(MOVE_GAP - 1) : '0;

   typedef enum logic [2:0] {IDLE, PICK, OFFER, GAP, DONE} state_t;

   state_t        state;
   logic [15:0]   lfsr;
   logic [15:0]   lfsr_next;
   logic [1:0]    prev_dir;
   logic          prev_valid;
   logic          armed;
   logic [GW-1:0] gap_cnt;
   logic [1:0]    cand;
   logic [1:0]    pick_dir;

   // Handshake: a move transfers on any cycle with move_valid && move_ready;
   // move_dir is held stable from the rise of move_valid until that cycle.

   assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ MASK) : (lfsr >> 1);
   assign cand      = lfsr[1:0];
   // Flipping bit 0 gives the opposite direction; flipping bit 1 turns sideways.
   assign pick_dir  = (prev_valid && (cand == (prev_dir ^ 2'b01))) ? (cand ^ 2'b10) : cand;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= IDLE;
         lfsr          <= SEED;
         prev_dir      <= 2'b00;
         prev_valid    <= 1'b0;
         armed         <= 1'b0;
         gap_cnt       <= '0;
         move_valid    <= 1'b0;
         move_dir      <= 2'b00;
         mix_state     <= 1'b0;
         scramble_done <= 1'b0;
         moves_left    <= 8'd0;
      end else begin
         lfsr <= lfsr_next;
         // Only a released button may arm the next scramble.
         if (!random_please) armed <= 1'b1;
         case (state)
            IDLE: begin
               if (random_please && armed) begin
                  state      <= PICK;
                  moves_left <= 8'(NUM_MOVES);
                  mix_state  <= 1'b1;
                  armed      <= 1'b0;
                  prev_valid <= 1'b0;
               end
            end
            PICK: begin
               move_dir   <= pick_dir;
               move_valid <= 1'b1;
               state      <= OFFER;
            end
            OFFER: begin
               if (move_ready) begin
                  prev_dir   <= move_dir;
                  prev_valid <= 1'b1;
                  moves_left <= moves_left - 8'd1;
                  move_valid <= 1'b0;
                  if (moves_left == 8'd1) begin
                     state         <= DONE;
                     scramble_done <= 1'b1;
                  end else if (MOVE_GAP == 0) begin
                     state <= PICK;
                  end else begin
                     state   <= GAP;
                     gap_cnt <= GAP_LOAD;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == '0) state <= PICK;
               else               gap_cnt <= gap_cnt - GW'(1);
            end
            DONE: begin
               scramble_done <= 1'b0;
               mix_state     <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_scramble_sequencer.sv
// Scoreboard bench for scramble_sequencer: an event-level reference model predicts
// each offered move and the per-cycle flags; a negedge monitor compares them.
module tb_scramble_sequencer;

   localparam int          NUM_MOVES = 31;
   localparam int          MOVE_GAP  = 4;
   localparam logic [15:0] SEED      = 16'hACE1;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       random_please = 1'b0;
   logic       move_ready = 1'b0;
   logic       move_valid;
   logic [1:0] move_dir;
   logic       mix_state;
   logic       scramble_done;
   logic [7:0] moves_left;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit check_en = 1'b0;
   int done_seen = 0;

   logic [1:0] acc_dirs[$];
   int         hs_cyc[$];
   logic [9:0] exp_q[$];

   scramble_sequencer #(.NUM_MOVES(NUM_MOVES), .MOVE_GAP(MOVE_GAP), .LFSR_SEED(SEED)) dut (
      .clk(clk), .reset_n(reset_n), .random_please(random_please), .move_ready(move_ready),
      .move_valid(move_valid), .move_dir(move_dir), .mix_state(mix_state),
      .scramble_done(scramble_done), .moves_left(moves_left)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   function automatic logic [1:0] opposite(input logic [1:0] d);
      case (d)
         2'd0: return 2'd1;
         2'd1: return 2'd0;
         2'd2: return 2'd3;
         default: return 2'd2;
      endcase
   endfunction

   function automatic logic [1:0] choose(input logic [15:0] v, input bit pv, input logic [1:0] pd);
      logic [1:0] c;
      c = v[1:0];
      if (pv && c == opposite(pd)) return (c < 2) ? c + 2'd2 : c - 2'd2;
      return c;
   endfunction

   // Reference model, event level: scramble start, pick instants, handshakes.
   logic [15:0] lfsr_m = SEED;
   bit          armed_m = 0, active = 0, offering = 0, in_done = 0, prev_v = 0;
   logic [1:0]  prev_d = 0, cur_d = 0;
   int          remaining = 0, pick_at = -1;
   logic        x_valid = 0, x_mix = 0, x_done = 0;
   logic [7:0]  x_moves = 0;

   always @(posedge clk) begin
      if (!reset_n) begin
         lfsr_m = SEED; armed_m = 0; active = 0; offering = 0; in_done = 0; prev_v = 0;
         x_valid = 0; x_mix = 0; x_done = 0; x_moves = 0; pick_at = -1;
         exp_q.delete();
         check_en = 1;
      end else begin
         if (in_done) begin
            x_done = 0; x_mix = 0; in_done = 0; active = 0;
         end else if (!active) begin
            if (random_please && armed_m) begin
               active = 1; remaining = NUM_MOVES; pick_at = cyc + 1; prev_v = 0;
               x_mix = 1; x_moves = 8'(NUM_MOVES); armed_m = 0;
            end
         end else if (cyc == pick_at) begin
            cur_d = choose(lfsr_m, prev_v, prev_d);
            exp_q.push_back({cur_d, 8'(remaining)});
            x_valid = 1; offering = 1;
         end else if (offering && move_ready) begin
            prev_d = cur_d; prev_v = 1; remaining--; x_moves = 8'(remaining);
            x_valid = 0; offering = 0;
            if (remaining == 0) begin
               in_done = 1; x_done = 1;
            end else begin
               pick_at = cyc + MOVE_GAP + 1;
            end
         end
         if (!random_please) armed_m = 1;
         lfsr_m = lfsr_step(lfsr_m);
      end
      cyc++;
   end

   // Monitor: compares DUT against the model between clock edges.
   always @(negedge clk) begin
      if (check_en) begin
         check("move_valid", 16'(move_valid), 16'(x_valid));
         check("mix_state", 16'(mix_state), 16'(x_mix));
         check("scramble_done", 16'(scramble_done), 16'(x_done));
         check("moves_left", 16'(moves_left), 16'(x_moves));
         if (move_valid) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL offer: move %0d offered at cycle %0d, none predicted", move_dir, cyc);
            end else begin
               check("move_dir", 16'(move_dir), 16'(exp_q[0][9:8]));
               check("offer_moves_left", 16'(moves_left), 16'(exp_q[0][7:0]));
               if (move_ready) begin
                  void'(exp_q.pop_front());
                  acc_dirs.push_back(move_dir);
                  hs_cyc.push_back(cyc);
               end
            end
         end
         if (scramble_done) done_seen++;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press();
      random_please = 1'b1;
      tick();
      random_please = 1'b0;
   endtask

   task automatic clear_log();
      acc_dirs.delete();
      hs_cyc.delete();
   endtask

   task automatic wait_done(input string name, input int budget, input bit rand_ready);
      int start;
      int k;
      start = done_seen;
      k = 0;
      while (done_seen == start && k < budget) begin
         if (rand_ready) move_ready = ($urandom_range(0, 3) != 0);
         tick();
         k++;
      end
      move_ready = 1'b1;
      total++;
      if (done_seen == start) begin
         bad++;
         $display("FAIL %s: no scramble_done within %0d cycles", name, budget);
      end
   endtask

   initial begin
      logic [1:0] seq1[$];
      logic [3:0] seen;
      int d0;
      int k;
      bit differs;

      // Reset held with the button down; no scramble may start on release.
      random_please = 1'b1; move_ready = 1'b1;
      tick(3);
      reset_n = 1'b1;
      tick(20);
      check("reset_hold_no_moves", 16'(acc_dirs.size()), 16'd0);
      check("reset_hold_no_done", 16'(done_seen), 16'd0);
      random_please = 1'b0;
      tick(2);

      // Full scramble, ready tied high.
      clear_log();
      press();
      wait_done("full_scramble", 400, 1'b0);
      check("full_count", 16'(acc_dirs.size()), 16'(NUM_MOVES));
      check("full_done_count", 16'(done_seen), 16'd1);
      for (int i = 1; i < hs_cyc.size(); i++)
         check("full_spacing", 16'(hs_cyc[i] - hs_cyc[i-1]), 16'(MOVE_GAP + 2));
      tick(3);

      // Backpressure on the first offer.
      clear_log();
      move_ready = 1'b0;
      press();
      k = 0;
      while (!move_valid && k < 10) begin tick(); k++; end
      check("bp_offer_seen", 16'(move_valid), 16'd1);
      tick(10);
      check("bp_no_handshake", 16'(acc_dirs.size()), 16'd0);
      move_ready = 1'b1;
      tick();
      check("bp_first_ready_handshake", 16'(acc_dirs.size()), 16'd1);
      wait_done("bp_scramble", 400, 1'b0);
      check("bp_count", 16'(acc_dirs.size()), 16'(NUM_MOVES));

      // Twenty scrambles at varied offsets with random backpressure.
      seen = 4'h0;
      for (int s = 0; s < 20; s++) begin
         tick($urandom_range(1, 9));
         clear_log();
         press();
         wait_done("rand_scramble", 1500, 1'b1);
         check("rand_count", 16'(acc_dirs.size()), 16'(NUM_MOVES));
         for (int i = 0; i < acc_dirs.size(); i++) begin
            seen[acc_dirs[i]] = 1'b1;
            if (i > 0) check("no_undo", 16'(acc_dirs[i] == opposite(acc_dirs[i-1])), 16'd0);
         end
      end
      check("all_dirs_seen", 16'(seen), 16'hF);

      // Button held for 300 cycles gives exactly one scramble.
      tick(2);
      clear_log();
      d0 = done_seen;
      random_please = 1'b1;
      tick(300);
      random_please = 1'b0;
      check("held_one_scramble", 16'(done_seen - d0), 16'd1);
      check("held_count", 16'(acc_dirs.size()), 16'(NUM_MOVES));
      seq1 = acc_dirs;
      tick(2);
      clear_log();
      press();
      wait_done("second_scramble", 400, 1'b0);
      check("second_count", 16'(acc_dirs.size()), 16'(NUM_MOVES));
      differs = 1'b0;
      for (int i = 0; i < acc_dirs.size() && i < seq1.size(); i++)
         if (acc_dirs[i] != seq1[i]) differs = 1'b1;
      check("second_sequence_differs", 16'(differs), 16'd1);

      // Reset right after the tenth handshake abandons the scramble.
      tick(3);
      clear_log();
      press();
      k = 0;
      while (acc_dirs.size() < 10 && k < 200) begin tick(); k++; end
      check("mid_ten_handshakes", 16'(acc_dirs.size()), 16'd10);
      d0 = done_seen;
      reset_n = 1'b0;
      tick();
      @(negedge clk);
      check("mid_rst_valid", 16'(move_valid), 16'd0);
      check("mid_rst_mix", 16'(mix_state), 16'd0);
      check("mid_rst_moves_left", 16'(moves_left), 16'd0);
      reset_n = 1'b1;
      tick(10);
      check("mid_rst_no_done", 16'(done_seen - d0), 16'd0);
      check("mid_rst_no_more_moves", 16'(acc_dirs.size()), 16'd10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
